// File: rtl/lsu_align_unit.sv
// lsu_align_unit: splits byte/half/word accesses into word transactions and merges/extends load lanes
module lsu_align_unit #(
    parameter int ADDRESS_SIZE = 32,
    parameter int BIT_COUNT    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ReqValid,
    output logic                      ReqReady,
    input  logic                      ReqWrite,
    input  logic [1:0]                ReqSize,
    input  logic                      ReqUnsigned,
    input  logic [ADDRESS_SIZE-1:0]   ReqAddr,
    input  logic [BIT_COUNT-1:0]      ReqWData,
    output logic                      RspValid,
    output logic                      RspError,
    output logic [BIT_COUNT-1:0]      RspRData,
    output logic                      MemEn,
    output logic                      MemWriteEn,
    output logic [BIT_COUNT/8-1:0]    MemByteEn,
    output logic [ADDRESS_SIZE-1:0]   MemAddress,
    output logic [BIT_COUNT-1:0]      MemWData,
    input  logic [BIT_COUNT-1:0]      MemRData
);
    localparam int LANES = BIT_COUNT / 8;

    typedef enum logic [1:0] {IDLE, ACCESS0, ACCESS1, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      write_q, write_d;
    logic [1:0]                size_q, size_d;
    logic                      uns_q, uns_d;
    logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
    logic [BIT_COUNT-1:0]      wdata_q, wdata_d;
    logic [BIT_COUNT-1:0]      word0_q, word0_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_error_q, rsp_error_d;
    logic [BIT_COUNT-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic [1:0]                offset;
    logic [2:0]                nbytes;
    logic                      crossing;
    logic [LANES-1:0]          size_mask;
    logic [2*LANES-1:0]        lane_mask;
    logic [2*BIT_COUNT-1:0]    wdata_wide;
    logic [2*BIT_COUNT-1:0]    rdata_wide;
    logic [2*BIT_COUNT-1:0]    rdata_shift;
    logic [BIT_COUNT-1:0]      load_result;
    logic [ADDRESS_SIZE-1:0]   word_addr;
    logic                      active;
    logic                      second;

    assign offset      = addr_q[1:0];
    assign nbytes      = size_q == 2'd0 ? 3'd1 : size_q == 2'd1 ? 3'd2 : 3'd4;
    assign crossing    = ({1'b0, offset} + nbytes) > 3'd4;
    assign size_mask   = size_q == 2'd0 ? LANES'(1) : size_q == 2'd1 ? LANES'(3) : {LANES{1'b1}};
    assign lane_mask   = {{LANES{1'b0}}, size_mask} << offset;
    assign wdata_wide  = {{BIT_COUNT{1'b0}}, wdata_q} << {offset, 3'b000};
    assign word_addr   = {addr_q[ADDRESS_SIZE-1:2], 2'b00};
    // The second word's lanes come straight from storage; the first was captured in ACCESS0
    assign rdata_wide  = state_q == ACCESS1 ? {MemRData, word0_q} : {{BIT_COUNT{1'b0}}, MemRData};
    assign rdata_shift = rdata_wide >> {offset, 3'b000};
    assign load_result = size_q == 2'd0 ? {{(BIT_COUNT-8){~uns_q & rdata_shift[7]}}, rdata_shift[7:0]} :
                         size_q == 2'd1 ? {{(BIT_COUNT-16){~uns_q & rdata_shift[15]}}, rdata_shift[15:0]} :
                         rdata_shift[BIT_COUNT-1:0];

    // Reset gates the storage port so an abandoned request issues no further cycle
    assign active     = ~reset & (state_q == ACCESS0 | state_q == ACCESS1);
    assign second     = state_q == ACCESS1;
    assign ReqReady   = ~reset & (state_q == IDLE);
    assign MemEn      = active;
    assign MemWriteEn = active & write_q;
    assign MemByteEn  = !active ? '0 : second ? lane_mask[2*LANES-1:LANES] : lane_mask[LANES-1:0];
    assign MemAddress = !active ? '0 : second ? word_addr + ADDRESS_SIZE'(4) : word_addr;
    assign MemWData   = !active ? '0 : second ? wdata_wide[2*BIT_COUNT-1:BIT_COUNT] : wdata_wide[BIT_COUNT-1:0];
    assign RspValid   = rsp_valid_q;
    assign RspError   = rsp_error_q;
    assign RspRData   = rsp_rdata_q;

    // Next-state: latch request, step through word accesses, build the response on entry to RESP
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: if (ReqValid & ReqReady) begin
                write_d = ReqWrite;
                size_d  = ReqSize;
                uns_d   = ReqUnsigned;
                addr_d  = ReqAddr;
                wdata_d = ReqWData;
                state_d = ReqSize == 2'd3 ? RESP : ACCESS0;
                if (ReqSize == 2'd3) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ACCESS0: begin
                word0_d = MemRData;
                state_d = crossing ? ACCESS1 : RESP;
                if (!crossing) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = write_q ? '0 : load_result;
                end
            end
            ACCESS1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = write_q ? '0 : load_result;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word0_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word0_q     <= word0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store alignment unit between the execute/memory pipeline stage and the word-organised data storage.
- Accepts byte, halfword and word loads/stores at any byte address.
- Splits word-crossing accesses into two word transactions, generating byte enables and lane-shifted write data.
- Merges read lanes and sign- or zero-extends load results; returns one response per request over a valid/ready handshake.

Parameters:
- ADDRESS_SIZE, 32, width of byte addresses on request and memory sides.
- BIT_COUNT, 32, data word width; only 32 is supported (4 byte lanes).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  unit can accept a request
- ReqWrite  input  1  1 = store, 0 = load
- ReqSize  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- ReqUnsigned  input  1  load zero-extends when 1
- ReqAddr  input  ADDRESS_SIZE  byte address
- ReqWData  input  BIT_COUNT  store data, right-aligned
- RspValid  output  1  one-cycle response pulse
- RspError  output  1  illegal size, valid with RspValid
- RspRData  output  BIT_COUNT  load result (0 for stores and errors)
- MemEn  output  1  storage enable
- MemWriteEn  output  1  storage write enable
- MemByteEn  output  BIT_COUNT/8  lane enables
- MemAddress  output  ADDRESS_SIZE  word-aligned byte address (low 2 bits 0)
- MemWData  output  BIT_COUNT  lane-positioned write data
- MemRData  input  BIT_COUNT  combinational read data for MemAddress

Behaviour:
- Reset and clocking
  - Sync reset only; clock is clk. During reset and after it: state IDLE, RspValid=0, RspError=0, RspRData=0, ReqReady=0 while reset is high.
- Memory-side idle values
  - Outside ACCESS0/ACCESS1: MemEn=0, MemWriteEn=0, MemByteEn=0, MemAddress=0, MemWData=0.
- FSM states: IDLE, ACCESS0, ACCESS1, RESP.
- IDLE
  - ReqReady=1.
  - On ReqValid&ReqReady, latch all request fields and go to ACCESS0.
  - ReqReady is 0 in every other state; there is no back-pressure on responses.
- Lane arithmetic
  - o = ReqAddr[1:0]; n = 1/2/4 bytes for ReqSize 0/1/2; crossing = (o+n > 4).
- ACCESS0
  - MemEn=1, MemWriteEn=ReqWrite, MemAddress=ReqAddr with low 2 bits cleared.
  - MemByteEn bits o..min(o+n,4)-1 set; MemWData = ReqWData << 8*o.
  - Load lanes are captured from MemRData at the clock edge.
  - Next state: ACCESS1 if crossing, else RESP.
- ACCESS1
  - MemAddress = word0 address + 4, modulo 2^ADDRESS_SIZE (wraps to 0).
  - MemByteEn bits 0..(o+n-5) set; MemWData = ReqWData >> 8*(4-o).
  - Capture lanes, then go to RESP.
- Load merge
  - Result byte k = word0 byte (o+k) if o+k<4, else word1 byte (o+k-4), for k < n.
  - Bytes k ≥ n are filled with bit 8n-1 of the result if signed, else 0.
- RESP
  - RspValid=1 for exactly one cycle with RspRData/RspError; then return to IDLE.
  - RspRData and RspError hold their values after the pulse until the next RESP.
- Latency, measured from the accept edge T
  - Aligned/non-crossing: ACCESS0 at T+1, RspValid at T+2.
  - Crossing: RspValid at T+3.
  - Back-to-back throughput: one request per 3 (or 4) cycles.
- Illegal size (ReqSize=3)
  - Accepted; ACCESS0/ACCESS1 skipped (no MemEn); goes IDLE→RESP.
  - RspError=1, RspRData=0, RspValid at T+1.
- Word-size requests at o≠0 are legal and split.
- Reset mid-operation
  - Immediately abandons the request; no further memory cycle and no RspValid.
  - A store half already written in ACCESS0 stays written.

Test Plan:
- Preload mem[0x100]=0x44332211 and mem[0x104]=0x88776655. Load word at 0x100 → one access (MemByteEn=1111, MemAddress=0x100); RspValid at T+2, RspRData=0x44332211.
- Load half, signed, at 0x103 → ACCESS0 0x100 BE=1000, ACCESS1 0x104 BE=0001; RspValid at T+3, RspRData=0x00005544. Load byte at 0x107: signed → 0xFFFFFF88, unsigned → 0x00000088.
- Store word 0xDEADBEEF at 0x102 → ACCESS0 0x100 BE=1100 WData=0xBEEF0000; ACCESS1 0x104 BE=0011 WData=0x0000DEAD. Follow-up loads: 0x100 → 0xBEEF2211, 0x104 → 0x8877DEAD.
- Load word at 0xFFFFFFFE → MemAddress 0xFFFFFFFC then 0x00000000; lanes merged correctly.
- Assert reset during ACCESS1 of a crossing store → ACCESS1 write not issued; no RspValid. ReqReady=1 in the first cycle after reset deasserts.
- ReqSize=3 → MemEn stays 0; RspValid at T+1 with RspError=1, RspRData=0. ReqValid held high while busy → ReqReady=0 and only one request is accepted per response.
